// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, control-field widths and bit positions for the pipeline control sequencer
package pipe_ctrl_pkg;
    localparam int WB_W = 2;
    localparam int M_W = 3;
    localparam int EX_W = 8;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH = 2;
    localparam int M_MEMREAD = 1;
    localparam int M_MEMWRITE = 0;
    localparam int EX_REGDST = 7;
    localparam int EX_ALUSRC = 6;
    localparam logic [5:0] OP_LOAD = 6'b100100;
    localparam logic [5:0] OP_STORE = 6'b100101;
    localparam logic [5:0] OP_R0 = 6'b000001;
    localparam logic [5:0] OP_R1 = 6'b000011;
    localparam logic [5:0] OP_R2 = 6'b000101;
    localparam logic [5:0] OP_R3 = 6'b000110;
    localparam logic [5:0] OP_IMM0 = 6'b100000;
    localparam logic [5:0] OP_IMM1 = 6'b100001;
    localparam logic [5:0] OP_BR0 = 6'b101000;
    localparam logic [5:0] OP_BR1 = 6'b101001;
    localparam logic [5:0] OP_BR2 = 6'b101010;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode to WB/M/EX control bundle plus whether the instruction reads rt
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0]      opcode,
    output logic [WB_W-1:0] wb,
    output logic [M_W-1:0]  m,
    output logic [EX_W-1:0] ex,
    output logic            reads_rt
);
    always_comb begin
        {wb, m, ex, reads_rt} = '0;
        case (opcode)
            OP_LOAD:  {wb, m, ex, reads_rt} = {2'b11, 3'b010, 8'b01001001, 1'b0};
            OP_STORE: {wb, m, ex, reads_rt} = {2'b00, 3'b001, 8'b01001011, 1'b1};
            OP_R0:    {wb, m, ex, reads_rt} = {2'b10, 3'b000, 8'b10000010, 1'b1};
            OP_R1:    {wb, m, ex, reads_rt} = {2'b10, 3'b000, 8'b10000110, 1'b1};
            OP_R2:    {wb, m, ex, reads_rt} = {2'b10, 3'b000, 8'b10001010, 1'b1};
            OP_R3:    {wb, m, ex, reads_rt} = {2'b10, 3'b000, 8'b10001100, 1'b1};
            OP_IMM0:  {wb, m, ex, reads_rt} = {2'b10, 3'b000, 8'b01000001, 1'b0};
            OP_IMM1:  {wb, m, ex, reads_rt} = {2'b10, 3'b000, 8'b01000011, 1'b0};
            OP_BR0:   {wb, m, ex, reads_rt} = {2'b00, 3'b100, 8'b01010000, 1'b1};
            OP_BR1:   {wb, m, ex, reads_rt} = {2'b00, 3'b100, 8'b01010010, 1'b1};
            OP_BR2:   {wb, m, ex, reads_rt} = {2'b00, 3'b100, 8'b01010100, 1'b1};
            default:  {wb, m, ex, reads_rt} = '0;
        endcase
    end
endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// pipe_ctrl_sequencer: stages decoded control through ID/EX, EX/MEM, MEM/WB with load-use stalls and branch flushes
module pipe_ctrl_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             branch_taken,
    output logic [1:0]       id_ex_wb,
    output logic [2:0]       id_ex_m,
    output logic [7:0]       id_ex_ex,
    output logic [REG_W-1:0] id_ex_dst,
    output logic [1:0]       ex_mem_wb,
    output logic [2:0]       ex_mem_m,
    output logic [REG_W-1:0] ex_mem_dst,
    output logic [1:0]       mem_wb_wb,
    output logic [REG_W-1:0] mem_wb_dst,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic [WB_W-1:0] dec_wb;
    logic [M_W-1:0]  dec_m;
    logic [EX_W-1:0] dec_ex;
    logic            dec_rt;
    logic            flush;
    logic            stall;

    ctrl_decode u_decode (
        .opcode   (opcode),
        .wb       (dec_wb),
        .m        (dec_m),
        .ex       (dec_ex),
        .reads_rt (dec_rt)
    );

    // a taken branch squashes the younger instructions, so it overrides any load-use stall
    always_comb begin
        flush = ex_mem_m[M_BRANCH] & branch_taken;
        stall = !flush && id_ex_m[M_MEMREAD] && id_ex_dst != '0
                && (id_ex_dst == rs || (dec_rt && id_ex_dst == rt));
    end

    assign pc_write = !stall;
    assign ifid_write = !stall;
    assign ifid_flush = flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {id_ex_wb, id_ex_m, id_ex_ex, id_ex_dst} <= '0;
            {ex_mem_wb, ex_mem_m, ex_mem_dst} <= '0;
            {mem_wb_wb, mem_wb_dst} <= '0;
            bubble_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            {id_ex_wb, id_ex_m, id_ex_ex, id_ex_dst} <= (stall || flush) ? '0
                : {dec_wb, dec_m, dec_ex, dec_ex[EX_REGDST] ? rd : rt};
            {ex_mem_wb, ex_mem_m, ex_mem_dst} <= flush ? '0 : {id_ex_wb, id_ex_m, id_ex_dst};
            {mem_wb_wb, mem_wb_dst} <= {ex_mem_wb, ex_mem_dst};
            bubble_cnt <= (stall && bubble_cnt != '1) ? bubble_cnt + CNT_W'(1) : bubble_cnt;
            flush_cnt <= (flush && flush_cnt != '1) ? flush_cnt + CNT_W'(1) : flush_cnt;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// tb_pipe_ctrl_sequencer: directed checks of decode staging, load-use stalls, flushes, saturation and reset
module tb_pipe_ctrl_sequencer;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] LD = 6'b100100;
    localparam logic [5:0] ST = 6'b100101;
    localparam logic [5:0] RT = 6'b000001;
    localparam logic [5:0] IM = 6'b100000;
    localparam logic [5:0] BR = 6'b101000;

    logic clk = 0;
    logic rst = 1;
    logic [5:0] opcode = '0;
    logic [REG_W-1:0] rs = '0, rt = '0, rd = '0;
    logic branch_taken = 0;
    logic [1:0] id_ex_wb, ex_mem_wb, mem_wb_wb;
    logic [2:0] id_ex_m, ex_mem_m;
    logic [7:0] id_ex_ex;
    logic [REG_W-1:0] id_ex_dst, ex_mem_dst, mem_wb_dst;
    logic pc_write, ifid_write, ifid_flush;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;
    int checks = 0;
    int failures = 0;

    pipe_ctrl_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .branch_taken(branch_taken),
        .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex), .id_ex_dst(id_ex_dst),
        .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .ex_mem_dst(ex_mem_dst),
        .mem_wb_wb(mem_wb_wb), .mem_wb_dst(mem_wb_dst),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic bt);
        opcode = op; rs = s; rt = t; rd = d; branch_taken = bt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        check("rst_pc_write", pc_write, 1);
        check("rst_flush", ifid_flush, 0);
        // R-type walks through all three stages
        drive(RT, 1, 2, 3, 0);
        tick();
        check("r_idex_wb", id_ex_wb, 2'b10);
        check("r_idex_ex", id_ex_ex, 8'h82);
        check("r_idex_dst", id_ex_dst, 3);
        drive(NOP, 0, 0, 0, 0);
        tick();
        check("r_exmem_wb", ex_mem_wb, 2'b10);
        check("r_exmem_dst", ex_mem_dst, 3);
        check("nop_idex_wb", id_ex_wb, 0);
        tick();
        check("r_memwb_wb", mem_wb_wb, 2'b10);
        check("r_memwb_dst", mem_wb_dst, 3);
        // load rt=5 then R-type reading r5
        drive(LD, 1, 5, 0, 0);
        tick();
        check("ld_idex_m", id_ex_m, 3'b010);
        check("ld_idex_dst", id_ex_dst, 5);
        drive(RT, 5, 6, 7, 0);
        check("stall_pc_write", pc_write, 0);
        check("stall_ifid_write", ifid_write, 0);
        tick();
        check("bubble_idex_wb", id_ex_wb, 0);
        check("bubble_idex_m", id_ex_m, 0);
        check("bubble_cnt1", bubble_cnt, 1);
        check("ld_exmem_m", ex_mem_m, 3'b010);
        check("post_stall_pc", pc_write, 1);
        tick();
        check("r_after_stall_wb", id_ex_wb, 2'b10);
        check("r_after_stall_dst", id_ex_dst, 7);
        check("ld_memwb_wb", mem_wb_wb, 2'b11);
        // rt dependence only stalls instructions that read rt
        drive(LD, 1, 5, 0, 0);
        tick();
        drive(IM, 1, 5, 9, 0);
        check("imm_rt_no_stall", pc_write, 1);
        drive(ST, 1, 5, 9, 0);
        check("store_rt_stall", pc_write, 0);
        tick();
        check("bubble_cnt2", bubble_cnt, 2);
        // load into r0 never stalls
        drive(LD, 1, 0, 0, 0);
        tick();
        drive(RT, 0, 0, 2, 0);
        check("r0_no_stall", pc_write, 1);
        tick();
        check("r0_bubble_cnt", bubble_cnt, 2);
        check("r0_idex_wb", id_ex_wb, 2'b10);
        // untaken branch in EX/MEM
        drive(BR, 1, 2, 0, 0);
        tick();
        check("br_idex_m", id_ex_m, 3'b100);
        drive(RT, 1, 2, 4, 0);
        tick();
        check("br_exmem_m", ex_mem_m, 3'b100);
        check("untaken_flush", ifid_flush, 0);
        drive(IM, 1, 2, 4, 0);
        tick();
        check("untaken_idex_wb", id_ex_wb, 2'b10);
        check("untaken_flush_cnt", flush_cnt, 0);
        // taken branch
        drive(BR, 1, 2, 0, 0);
        tick();
        drive(RT, 1, 2, 4, 0);
        tick();
        drive(IM, 1, 2, 4, 1);
        check("taken_flush", ifid_flush, 1);
        check("taken_pc_write", pc_write, 1);
        tick();
        check("flush_idex_wb", id_ex_wb, 0);
        check("flush_exmem_wb", ex_mem_wb, 0);
        check("flush_exmem_m", ex_mem_m, 0);
        check("flush_cnt1", flush_cnt, 1);
        check("bt_ignored", ifid_flush, 0);
        // flush and load-use together
        drive(BR, 1, 2, 0, 0);
        tick();
        drive(LD, 1, 5, 0, 0);
        tick();
        drive(RT, 5, 6, 7, 1);
        check("both_flush", ifid_flush, 1);
        check("both_pc_write", pc_write, 1);
        check("both_ifid_write", ifid_write, 1);
        tick();
        check("both_bubble_cnt", bubble_cnt, 2);
        check("both_flush_cnt", flush_cnt, 2);
        check("both_exmem_m", ex_mem_m, 0);
        // saturate both counters
        drive(BR, 1, 2, 0, 1);
        for (int i = 0; i < 60; i++) tick();
        check("flush_sat", flush_cnt, 15);
        drive(LD, 5, 5, 0, 0);
        for (int i = 0; i < 40; i++) tick();
        check("bubble_sat", bubble_cnt, 15);
        tick();
        tick();
        check("bubble_sat_hold", bubble_cnt, 15);
        check("flush_sat_hold", flush_cnt, 15);
        // asynchronous reset mid-stream
        rst = 1;
        #1;
        check("arst_idex_m", id_ex_m, 0);
        check("arst_exmem_m", ex_mem_m, 0);
        check("arst_memwb_wb", mem_wb_wb, 0);
        check("arst_dst", {id_ex_dst, ex_mem_dst, mem_wb_dst}, 0);
        check("arst_bubble", bubble_cnt, 0);
        check("arst_flush_cnt", flush_cnt, 0);
        check("arst_pc_write", pc_write, 1);
        check("arst_ifid_flush", ifid_flush, 0);
        tick();
        rst = 0;
        tick();
        check("post_rst_load", id_ex_m, 3'b010);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
